// File: rtl/proc_mul_pkg.sv
// Shared definitions for the multiplier combine stage: widths, the stage-A
// record layout and the two arithmetic steps of the low-word product.
package proc_mul_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_HALF_W = 16;
    localparam int MUL_TAG_W  = 5;

    // Contents of stage A: low partial product, folded cross term and tag.
    typedef struct packed {
        logic [MUL_DATA_W-1:0] p1;
        logic [MUL_HALF_W-1:0] mid;
        logic [MUL_TAG_W-1:0]  tag;
    } mul_stage_a_t;

    // Only the low halves of the cross products reach the low 32 bits of
    // a*b, and the carry out of their sum lands at bit 32, so it is dropped.
    function automatic logic [MUL_HALF_W-1:0] mul_mid_sum(
        input logic [MUL_HALF_W-1:0] p2_lo,
        input logic [MUL_HALF_W-1:0] p3_lo
    );
        return p2_lo + p3_lo;
    endfunction

    // Low word of the product: p1 plus the cross term shifted up by 16, mod 2^32.
    function automatic logic [MUL_DATA_W-1:0] mul_low_word(
        input logic [MUL_DATA_W-1:0] p1,
        input logic [MUL_HALF_W-1:0] mid
    );
        return p1 + {mid, {MUL_HALF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/proc_mul_pipe_reg.sv
// Generic valid/ready register slice with synchronous flush. The ready
// output is combinational from the downstream ready, so a full slice that is
// being drained can take new data in the same cycle (no skid buffer).
module proc_mul_pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Occupancy: flush empties the slice; otherwise it refills or empties
    // whenever it is free to move, and holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_ready) begin
            r_valid <= in_valid;
        end
    end

    // Payload: loaded only on an accepted transfer, so idle-cycle inputs
    // (possibly X) never reach the register and a stalled slice stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (in_valid && in_ready && !flush) begin
            r_data <= in_data;
        end
    end

endmodule

// File: rtl/proc_mul_combine.sv
// Combines the three registered 16x16 partial products of the multiplier cell
// into the low 32 bits of a*b over a two-slice elastic pipeline, carrying the
// destination tag alongside and honouring flush.
module proc_mul_combine
    import proc_mul_pkg::*;
#(
    parameter int TAG_W  = MUL_TAG_W,
    parameter int DATA_W = MUL_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] M_mul_cell_p1,
    input  logic [DATA_W-1:0] M_mul_cell_p2,
    input  logic [DATA_W-1:0] M_mul_cell_p3,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int A_W = DATA_W + MUL_HALF_W + TAG_W;
    localparam int B_W = DATA_W + TAG_W;

    logic [MUL_HALF_W-1:0] w_mid;
    logic [A_W-1:0]        w_a_in;
    logic [A_W-1:0]        w_a_out;
    logic                  w_a_valid;
    logic                  w_b_ready;
    logic [DATA_W-1:0]     w_a_p1;
    logic [MUL_HALF_W-1:0] w_a_mid;
    logic [TAG_W-1:0]      w_a_tag;
    logic [B_W-1:0]        w_b_in;
    logic [B_W-1:0]        w_b_out;
    logic                  w_unused_hi;

    // Upper halves of the cross products only affect bits above 31.
    assign w_unused_hi = ^{M_mul_cell_p2[DATA_W-1:MUL_HALF_W],
                           M_mul_cell_p3[DATA_W-1:MUL_HALF_W]};

    assign w_mid  = mul_mid_sum(M_mul_cell_p2[MUL_HALF_W-1:0],
                                M_mul_cell_p3[MUL_HALF_W-1:0]);
    assign w_a_in = {M_mul_cell_p1, w_mid, in_tag};

    proc_mul_pipe_reg #(.W(A_W)) u_stage_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_a_in),
        .out_valid (w_a_valid),
        .out_ready (w_b_ready),
        .out_data  (w_a_out)
    );

    assign {w_a_p1, w_a_mid, w_a_tag} = w_a_out;
    assign w_b_in = {mul_low_word(w_a_p1, w_a_mid), w_a_tag};

    proc_mul_pipe_reg #(.W(B_W)) u_stage_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (w_a_valid),
        .in_ready  (w_b_ready),
        .in_data   (w_b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_b_out)
    );

    assign {result, out_tag} = w_b_out;

endmodule

// File: tb/tb_proc_mul_combine.sv
// Directed bench for proc_mul_combine: a vector table applied one at a time
// and back-to-back, then backpressure, flush and async-reset sequences.
module tb_proc_mul_combine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] p1, p2, p3;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    proc_mul_combine dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .M_mul_cell_p1 (p1),
        .M_mul_cell_p2 (p2),
        .M_mul_cell_p3 (p3),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .out_tag       (out_tag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [4:0] t);
        in_valid = v;
        p1       = a1;
        p2       = a2;
        p3       = a3;
        in_tag   = t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int next;
        int acc;
        int got;

        vecs[0] = '{32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 5'd3,  32'h0016_0008};
        vecs[1] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd7,  32'h0000_0001};
        vecs[2] = '{32'h0000_0000, 32'h0000_FFFF, 32'h0000_0001, 5'd12, 32'h0000_0000};
        vecs[3] = '{32'h1234_5678, 32'hABCD_1111, 32'h0000_2222, 5'd31, 32'h4567_5678};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd0,  32'h0000_FFFF};
        vecs[5] = '{32'h0000_ABCD, 32'hFFFF_8000, 32'h1234_8000, 5'd17, 32'h0000_ABCD};

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // one product at a time: exactly two cycles from acceptance to out_valid
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].tag);
            #1;
            check("single_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("single_early_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            check("single_out_valid", 32'(out_valid), 32'd1);
            check("single_result",    result,         vecs[i].exp);
            check("single_out_tag",   32'(out_tag),   32'(vecs[i].tag));
        end

        // back-to-back stream: one result per cycle, in order
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 6) drive(1'b1, vecs[c].p1, vecs[c].p2, vecs[c].p3, vecs[c].tag);
            else       in_valid = 1'b0;
            #1;
            if (c >= 2 && c < 8) begin
                check("stream_valid",  32'(out_valid), 32'd1);
                check("stream_result", result,         vecs[c-2].exp);
                check("stream_tag",    32'(out_tag),   32'(vecs[c-2].tag));
            end else if (c == 8) begin
                check("stream_tail_valid", 32'(out_valid), 32'd0);
            end
        end

        // backpressure: only two products absorbed, outputs held while stalled
        next = 1;
        acc  = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            drive(1'b1, 32'(next), 32'h0, 32'h0, 5'(next));
            #1;
            if (in_ready) begin
                acc++;
                next++;
            end
        end
        check("bp_accepts",  32'(acc),       32'd2);
        check("bp_in_ready", 32'(in_ready),  32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("bp_hold_ready",  32'(in_ready),  32'd0);
            check("bp_hold_valid",  32'(out_valid), 32'd1);
            check("bp_hold_result", result,         32'd1);
            check("bp_hold_tag",    32'(out_tag),   32'd1);
        end
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (next <= 4) drive(1'b1, 32'(next), 32'h0, 32'h0, 5'(next));
            else           in_valid = 1'b0;
            #1;
            if (out_valid) begin
                check("bp_order_tag", 32'(out_tag), 32'(got + 1));
                check("bp_result",    result,       32'(got + 1));
                got++;
            end
            if (in_valid && in_ready) next++;
        end
        in_valid = 1'b0;
        check("bp_drained", 32'(got), 32'd4);
        @(negedge clk);
        #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // flush with two in flight and a third offered
        @(negedge clk);
        drive(1'b1, 32'd5, 32'h0, 32'h0, 5'd5);
        @(negedge clk);
        drive(1'b1, 32'd6, 32'h0, 32'h0, 5'd6);
        @(negedge clk);
        drive(1'b1, 32'd7, 32'h0, 32'h0, 5'd7);
        flush = 1'b1;
        #1;
        check("flush_in_ready",  32'(in_ready),  32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd1);
        check("flush_out_tag",   32'(out_tag),   32'd5);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_killed_b", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("flush_dropped_third", 32'(out_valid), 32'd0);
        @(negedge clk);
        drive(1'b1, 32'd8, 32'h0, 32'h0, 5'd8);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("post_flush_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("post_flush_valid",  32'(out_valid), 32'd1);
        check("post_flush_tag",    32'(out_tag),   32'd8);
        check("post_flush_result", result,         32'd8);

        // async reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'd9, 32'h0, 32'h0, 5'd9);
        @(negedge clk);
        drive(1'b1, 32'd10, 32'h0, 32'h0, 5'd10);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_tag",   32'(out_tag),   32'd9);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid",    32'(out_valid), 32'd0);
        check("async_rst_result",   result,         32'd0);
        check("async_rst_tag",      32'(out_tag),   32'd0);
        check("async_rst_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_empty", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
